// File: rtl/temp_pkg.sv
// Shared types and widths for the temperature sensor path.
package temp_pkg;

  localparam int unsigned TEMP_INT_W    = 6;
  localparam int unsigned TEMP_FRAC_W   = 4;
  localparam int unsigned TEMP_Q_W      = TEMP_INT_W + TEMP_FRAC_W;
  localparam int unsigned SENSOR_WORD_W = 16;
  localparam int unsigned SENSOR_RAW_W  = 13;

  localparam logic [TEMP_Q_W-1:0] TEMP_MAX_Q = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_CONVERT
  } reader_state_e;

  // One decoded sensor word, before any filtering.
  typedef struct packed {
    logic                fault;
    logic                sat;
    logic [TEMP_Q_W-1:0] q;
  } sample_t;

endpackage

// File: rtl/sensor_spi_rx.sv
// SPI mode-0 read-only receiver: frames one 16-bit sensor word per start and
// pulses done (with cs_n already high) once the word is in data.
module sensor_spi_rx
  import temp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     miso,
  output logic                     cs_n,
  output logic                     sck,
  output logic                     ready_c,
  output logic                     done,
  output logic [SENSOR_WORD_W-1:0] data
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF_W = $clog2(2 * SENSOR_WORD_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * SENSOR_WORD_W - 1);

  reader_state_e     state;
  logic [DIV_W-1:0]  div_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              div_last_c;

  assign div_last_c = (div_cnt == DIV_LAST);
  assign ready_c    = (state == ST_IDLE);

  // Frame sequencer: setup, 32 sck half-periods, hold, then one convert cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      done     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            cs_n    <= 1'b0;
            div_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (div_last_c) begin
            state    <= ST_SHIFT;
            div_cnt  <= '0;
            half_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (div_last_c) begin
            div_cnt <= '0;
            // sck low now means this boundary is a rising edge: sample miso
            if (!sck) begin
              data <= {data[SENSOR_WORD_W-2:0], miso};
            end
            if (half_cnt == HALF_LAST) begin
              state <= ST_HOLD;
              sck   <= 1'b0;
            end else begin
              sck      <= ~sck;
              half_cnt <= half_cnt + HALF_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (div_last_c) begin
            state <= ST_CONVERT;
            cs_n  <= 1'b1;
            done  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_CONVERT: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI temperature sensor reader producing clamped 6.4 fixed-point readings.
// Define TEMP_READER_FILTER_EN to average the last four accepted samples.
module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   sensor_miso,
  output logic                   sensor_cs_n,
  output logic                   sensor_sck,
  output logic [TEMP_INT_W-1:0]  temp,
  output logic [TEMP_FRAC_W-1:0] temp_frac,
  output logic                   temp_valid,
  output logic                   temp_sat,
  output logic                   sensor_fault
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD);

  logic [CNT_W-1:0]         period_cnt;
  logic                     start_c;
  logic                     rx_ready_c;
  logic                     rx_done;
  logic [SENSOR_WORD_W-1:0] rx_data;
  logic [SENSOR_RAW_W-1:0]  raw_c;
  sample_t                  sample_c;
  logic [TEMP_Q_W-1:0]      out_q_c;

  assign start_c = enable && (period_cnt == '0) && rx_ready_c;

  // Conversion period: reload on each start, count down to zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (start_c) begin
      period_cnt <= CNT_W'(SAMPLE_PERIOD - 1);
    end else if (period_cnt != '0) begin
      period_cnt <= period_cnt - CNT_W'(1);
    end
  end

  sensor_spi_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_c),
    .miso    (sensor_miso),
    .cs_n    (sensor_cs_n),
    .sck     (sensor_sck),
    .ready_c (rx_ready_c),
    .done    (rx_done),
    .data    (rx_data)
  );

  assign raw_c = rx_data[SENSOR_WORD_W-1 -: SENSOR_RAW_W];

  // Decode: reject open line / bad tag bits, clamp to 0 .. 63.9375.
  always_comb begin
    sample_c.fault = (rx_data == '1) || (rx_data[1:0] != 2'b11);
    sample_c.sat   = 1'b0;
    sample_c.q     = raw_c[TEMP_Q_W-1:0];
    if (raw_c[SENSOR_RAW_W-1]) begin
      sample_c.sat = 1'b1;
      sample_c.q   = '0;
    end else if (raw_c[SENSOR_RAW_W-2:TEMP_Q_W] != '0) begin
      sample_c.sat = 1'b1;
      sample_c.q   = TEMP_MAX_Q;
    end
  end

`ifdef TEMP_READER_FILTER_EN
  localparam int unsigned SUM_W = TEMP_Q_W + 2;

  // The incoming sample is the newest of the four entries; hist holds the older three.
  logic [TEMP_Q_W-1:0] hist [3];
  logic                hist_loaded;
  logic [SUM_W-1:0]    sum_c;

  always_comb begin
    if (hist_loaded) begin
      sum_c = SUM_W'(sample_c.q) + SUM_W'(hist[0]) + SUM_W'(hist[1]) + SUM_W'(hist[2]);
    end else begin
      sum_c = {sample_c.q, 2'b00};
    end
    out_q_c = sum_c[SUM_W-1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_loaded <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        hist[i] <= '0;
      end
    end else if (rx_done && !sample_c.fault) begin
      hist_loaded <= 1'b1;
      hist[0]     <= sample_c.q;
      if (hist_loaded) begin
        hist[1] <= hist[0];
        hist[2] <= hist[1];
      end else begin
        hist[1] <= sample_c.q;
        hist[2] <= sample_c.q;
      end
    end
  end
`else
  assign out_q_c = sample_c.q;
`endif

  // Output registers update only on a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp         <= '0;
      temp_frac    <= '0;
      temp_valid   <= 1'b0;
      temp_sat     <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (rx_done) begin
        if (sample_c.fault) begin
          sensor_fault <= 1'b1;
        end else begin
          sensor_fault <= 1'b0;
          temp_valid   <= 1'b1;
          temp_sat     <= sample_c.sat;
          temp         <= out_q_c[TEMP_Q_W-1:TEMP_FRAC_W];
          temp_frac    <= out_q_c[TEMP_FRAC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: sensor word model, per-cycle reference model
// and directed transactions with literal expectations.
module tb_temp_sensor_reader;

  localparam int D   = 2;
  localparam int SP  = 80;
  localparam int LAT = 34 * D + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       sensor_miso = 1'b0;
  logic       sensor_cs_n;
  logic       sensor_sck;
  logic [5:0] temp;
  logic [3:0] temp_frac;
  logic       temp_valid;
  logic       temp_sat;
  logic       sensor_fault;

  temp_sensor_reader #(
    .CLK_DIV       (D),
    .SAMPLE_PERIOD (SP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sensor_miso  (sensor_miso),
    .sensor_cs_n  (sensor_cs_n),
    .sensor_sck   (sensor_sck),
    .temp         (temp),
    .temp_frac    (temp_frac),
    .temp_valid   (temp_valid),
    .temp_sat     (temp_sat),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;
  bit done_flag = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Sensor: loads the next queued word on cs_n fall, shifts on sck fall.
  logic [15:0] wq[$];
  logic [15:0] cur_word = 16'h0D4B;
  logic [15:0] sh = 16'h0000;

  always @(negedge sensor_cs_n) begin
    if (rst_n) begin
      if (wq.size() > 0) cur_word = wq.pop_front();
      else cur_word = 16'h0D4B;
      sh = cur_word;
      sensor_miso = sh[15];
    end
  end

  always @(negedge sensor_sck) begin
    if (!sensor_cs_n) begin
      sh = {sh[14:0], 1'b0};
      sensor_miso = sh[15];
    end
  end

  // Reference model state.
  int   e = 0;
  int   m_last = -1;
  int   m_start = 0;
  bit   m_busy = 1'b0;
  logic [15:0] m_word = 16'h0000;
  int   m_temp = 0, m_frac = 0;
  bit   m_sat = 1'b0, m_fault = 1'b0;
  int   m_hist[3];
  bit   m_hist_ok = 1'b0;

  function automatic bit model_accept(input logic [15:0] w);
    int s, q;
    if (w == 16'hFFFF || w[1:0] != 2'b11) begin
      m_fault = 1'b1;
      return 1'b0;
    end
    s = int'(w[15:3]);
    if (s >= 4096) s = s - 8192;
    m_sat = (s < 0) || (s > 1023);
    q = (s < 0) ? 0 : ((s > 1023) ? 1023 : s);
`ifdef TEMP_READER_FILTER_EN
    if (!m_hist_ok) begin
      m_hist[0] = q; m_hist[1] = q; m_hist[2] = q;
      m_hist_ok = 1'b1;
    end
    begin
      int avg;
      avg = (q + m_hist[0] + m_hist[1] + m_hist[2]) / 4;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = q;
      q = avg;
    end
`endif
    m_temp  = q / 16;
    m_frac  = q % 16;
    m_fault = 1'b0;
    return 1'b1;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checking && !done_flag) begin
      int rel;
      bit ev, ecs, esck;
      e++;
      ev = 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0; m_last = -1;
        m_temp = 0; m_frac = 0; m_sat = 1'b0; m_fault = 1'b0;
        m_hist_ok = 1'b0;
      end else begin
        if (enable && !m_busy && (m_last < 0 || e - m_last >= SP)) begin
          m_busy = 1'b1; m_last = e; m_start = e; m_word = cur_word;
        end
        if (m_busy && e - m_start == LAT) begin
          m_busy = 1'b0;
          ev = model_accept(m_word);
        end
      end
      rel  = e - m_start;
      ecs  = !(m_busy && rel < 34 * D);
      esck = m_busy && rel >= D && rel < 33 * D && (((rel - D) / D) % 2 == 1);
      chk("cyc_cs_n", sensor_cs_n, ecs);
      chk("cyc_sck", sensor_sck, esck);
      chk("cyc_valid", temp_valid, ev);
      chk("cyc_temp", temp, m_temp);
      chk("cyc_frac", temp_frac, m_frac);
      chk("cyc_sat", temp_sat, m_sat);
      chk("cyc_fault", sensor_fault, m_fault);
    end
  end

  task automatic wait_cs_low(output int n);
    n = 0;
    while (sensor_cs_n !== 1'b0 && n < 3 * SP) begin
      @(negedge clk);
      n++;
    end
    chk("cs_fall", sensor_cs_n, 0);
  endtask

  task automatic finish_txn(output int n);
    n = 0;
    while (sensor_cs_n !== 1'b1 && n < 40 * D) begin
      @(negedge clk);
      n++;
    end
    chk("cs_rise", sensor_cs_n, 1);
    @(negedge clk);
    n++;
  endtask

  task automatic check_out(input string tag, input int t, input int f, input int v,
                           input int s, input int fl);
    chk($sformatf("%s_temp", tag), temp, t);
    chk($sformatf("%s_frac", tag), temp_frac, f);
    chk($sformatf("%s_valid", tag), temp_valid, v);
    chk($sformatf("%s_sat", tag), temp_sat, s);
    chk($sformatf("%s_fault", tag), sensor_fault, fl);
  endtask

  initial begin
    int n, lat, falls;
    logic prev;
`ifdef TEMP_READER_FILTER_EN
    int exp_t[4];
    exp_t = '{20, 20, 20, 21};
    wq = '{16'h0A03, 16'h0A03, 16'h0A03, 16'h0C03};
`else
    wq = '{16'h0D4B, 16'hFD83, 16'h2303, 16'h0D4B, 16'hFFFF,
           16'h0D48, 16'h2303, 16'h0A03, 16'h1003};
`endif
    #1 rst_n = 1'b0;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", sensor_cs_n, 1);
    chk("rst_sck", sensor_sck, 0);
    check_out("rst", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1; enable = 1'b1;

`ifdef TEMP_READER_FILTER_EN
    for (int i = 0; i < 4; i++) begin
      wait_cs_low(n);
      finish_txn(lat);
      check_out($sformatf("filt%0d", i), exp_t[i], 0, 1, 0, 0);
    end
`else
    wait_cs_low(n);
    chk("first_start", n, 1);
    finish_txn(lat);
    chk("latency", lat, LAT);
    check_out("t26", 26, 9, 1, 0, 0);

    wait_cs_low(n); finish_txn(lat);
    check_out("neg5", 0, 0, 1, 1, 0);
    wait_cs_low(n); finish_txn(lat);
    check_out("hot70", 63, 15, 1, 1, 0);
    wait_cs_low(n); finish_txn(lat);
    check_out("t26b", 26, 9, 1, 0, 0);
    wait_cs_low(n); finish_txn(lat);
    check_out("open", 26, 9, 0, 0, 1);
    wait_cs_low(n); finish_txn(lat);
    check_out("badtag", 26, 9, 0, 0, 1);

    // Reset inside the 8th sck period.
    wait_cs_low(n);
    repeat (16 * D) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", sensor_cs_n, 1);
    chk("rstmid_sck", sensor_sck, 0);
    check_out("rstmid", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cs_low(n);
    chk("restart_after_rst", n, 1);
    finish_txn(lat);
    chk("latency_after_rst", lat, LAT);
    check_out("t20", 20, 0, 1, 0, 0);

    // Drop enable mid-shift.
    wait_cs_low(n);
    repeat (10 * D) @(negedge clk);
    #2 enable = 1'b0;
    finish_txn(lat);
    check_out("en_drop", 32, 0, 1, 0, 0);
    falls = 0;
    prev = sensor_cs_n;
    repeat (3 * SP) begin
      @(negedge clk);
      if (prev && !sensor_cs_n) falls++;
      prev = sensor_cs_n;
    end
    chk("no_start_disabled", falls, 0);
    #2 enable = 1'b1;
    @(negedge clk);
    chk("reenable_start", sensor_cs_n, 0);
    n = 0;
    prev = 1'b0;
    while (n < 2 * SP) begin
      @(negedge clk);
      n++;
      if (prev && !sensor_cs_n) break;
      prev = sensor_cs_n;
    end
    chk("period", n, SP);
    finish_txn(lat);
    check_out("t26c", 26, 9, 1, 0, 0);
`endif
    done_flag = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    if (!done_flag) begin
      done_flag = 1'b1;
      miscompares++;
      $display("FAIL watchdog: got timeout, expected sequence completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Producer side of the temperature path: periodically reads a serial (SPI-mode-0, read-only) digital temperature sensor, converts its 13-bit two's-complement word (LSB = 1/16 °C) into the unsigned 6.4 fixed-point `temp`/`temp_frac` format consumed by the temperature monitor, and flags each new reading with a one-cycle strobe. Sits between the board sensor pins and the monitor; one instance per sensor.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sensor_sck` half-period; legal values are 1 or greater.
- `SAMPLE_PERIOD`, 50000: `clk` cycles between conversion starts; legal values are `34*CLK_DIV+2` or greater.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new conversions to start.
- `sensor_miso`  in  1  serial data from the sensor, MSB first.
- `sensor_cs_n`  out  1  sensor chip select, active low.
- `sensor_sck`  out  1  serial clock; idles low.
- `temp`  out  6  integer °C, clamped to the range 0..63.
- `temp_frac`  out  4  fractional °C in 1/16 units.
- `temp_valid`  out  1  one-cycle pulse asserted when `temp`/`temp_frac` update.
- `temp_sat`  out  1  last accepted reading was clamped (below 0 or above 63.9375).
- `sensor_fault`  out  1  last transaction was rejected.

## Operation
- **Reset values:** `sensor_cs_n`=1, `sensor_sck`=0, `temp`=0, `temp_frac`=0, `temp_valid`=0, `temp_sat`=0, `sensor_fault`=0. State=IDLE. Period counter=0.
- **FSM states:**
  - IDLE → SETUP when `enable`=1 and the period counter is 0. The counter reloads to `SAMPLE_PERIOD-1` on that transition.
  - SETUP: `cs_n`=0 for `CLK_DIV` cycles.
  - SHIFT: 16 full `sck` periods.
  - HOLD: `sck`=0, `cs_n`=0 for `CLK_DIV` cycles.
  - CONVERT: lasts 1 cycle with `cs_n`=1, then → IDLE.
- **Period counter:** decrements every cycle while nonzero, in all states.
- **Shift:** `sck` toggles every `CLK_DIV` cycles. `sensor_miso` is sampled into a 16-bit shift register on each `sck` rising edge, MSB first.
- **Decode, word w:**
  - Fault if `w`==16'hFFFF (open line) or `w[1:0]`≠2'b11. On fault: `sensor_fault`=1, no `temp_valid`, while `temp`, `temp_frac` and `temp_sat` hold.
  - Otherwise `s` = signed `w[15:3]` (13 bit).
    - `s`<0 → value 0.0, `temp_sat`=1.
    - `s`>1023 → value 63.9375 (`temp`=63, `frac`=15), `temp_sat`=1.
    - Else `temp`=`s[9:4]`, `temp_frac`=`s[3:0]`, `temp_sat`=0.
  - In all non-fault cases `sensor_fault`=0 and `temp_valid`=1.
- **`enable` low mid-transaction:** the transaction completes normally; no new start occurs.
- **Reset mid-transaction:** all outputs return to reset values immediately (asynchronously). The partial word is discarded.

## Timing
- Latency from `cs_n` fall to `temp_valid` is `34*CLK_DIV+1` cycles.
- Outputs update in the same cycle `temp_valid` is high.
- First conversion: `cs_n` falls on the first rising `clk` after `rst_n` deasserts with `enable`=1.
- Consecutive `cs_n` falls are exactly `SAMPLE_PERIOD` cycles apart while `enable` stays high.
- If `enable` rises while the counter is 0, the conversion starts on the next edge.

## Configuration
- **`TEMP_READER_FILTER_EN` defined:** accepted clamped 10-bit values go into a 4-entry history.
  - The first accepted sample after reset loads all 4 entries.
  - Output = (sum of 4 entries) >> 2, truncated, using a 12-bit sum.
  - `temp_valid` timing is unchanged.
  - `temp_sat` reflects the newest raw sample.
  - Faulted samples do not enter the history.
- **Undefined:** the raw converted value is output directly; no history registers are present.

## Structure
- **Shared package `temp_pkg`:**
  - `TEMP_INT_W`=6, `TEMP_FRAC_W`=4, `SENSOR_WORD_W`=16.
  - The reader FSM state enum.
  - `TEMP_MAX_Q`=10'h3FF.
- **Sub-module `sensor_spi_rx`:** generates `sck`/`cs_n` and shifts in the word (`start`/`done` handshake, 16-bit `data` output). Decode, clamp and filter stay in the top module.

## Test plan
- Sensor returns 16'h0D4B (26.5625 °C) → `temp`=26, `temp_frac`=9, one `temp_valid` pulse, `temp_sat`=0, `sensor_fault`=0, pulse exactly `34*CLK_DIV+1` cycles after `cs_n` fall.
- Sensor returns 16'hFD83 (−5 °C) → `temp`=0, `temp_frac`=0, `temp_sat`=1. Then 16'h2303 (70 °C) → `temp`=63, `temp_frac`=15, `temp_sat`=1.
- Sensor returns 16'hFFFF, then 16'h0D48 → `sensor_fault`=1 both times, no `temp_valid`, `temp`/`temp_frac` hold the prior 26/9.
- `rst_n` pulsed low during the 8th `sck` period → `cs_n`=1 and `sck`=0 immediately, all outputs at 0. After release with `enable`=1, a full 16-bit transaction starts on the next edge.
- `enable` deasserted mid-SHIFT → current reading still delivered, no further `cs_n` fall for 3×`SAMPLE_PERIOD`. Re-enable → start within 1 cycle once the counter is 0; period between starts measured as `SAMPLE_PERIOD`.
- With `TEMP_READER_FILTER_EN`: samples 20.0, 20.0, 20.0, 24.0 °C → outputs 20.0, 20.0, 20.0, 21.0 (`temp`=21, `temp_frac`=0).
